// File: rtl/axis_frame_sender.sv
//==============================================================================
// Module      : axis_frame_sender
// Description : AXI4-Stream frame source. On en, snapshots N_WORDS payload words
//               and streams them as one frame with tlast on the final word.
//               Optional feature macro: AXIS_FRAME_SKIP_ZERO_EN (skip zero
//               non-final words with a tvalid=0 slot).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axis_frame_sender #(
    parameter int DATA_W   = 32,
    parameter int N_WORDS  = 3,
    parameter int ONE_SHOT = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_WORDS*DATA_W-1:0]   words,
    input  logic                        tready,
    output logic [DATA_W-1:0]           tdata,
    output logic                        tvalid,
    output logic                        tlast,
    output logic [DATA_W/8-1:0]         tkeep,
    output logic                        busy,
    output logic                        done
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int IDX_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

`ifdef AXIS_FRAME_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  idx_q, idx_d;
    logic [N_WORDS-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic [DATA_W-1:0]                 tdata_q, tdata_d;
    logic                              tvalid_q, tvalid_d;
    logic                              tlast_q, tlast_d;
    logic [KEEP_W-1:0]                 tkeep_q, tkeep_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;

    logic [IDX_W-1:0]                  nxt_idx;
    logic [DATA_W-1:0]                 nxt_word;
    logic                              nxt_last;
    logic                              advance;
    logic [DATA_W-1:0]                 pres_word;
    logic                              pres_last;
    logic                              pres_en;
    logic                              pres_valid;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tkeep_d    = tkeep_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pres_en    = 1'b0;
        pres_word  = '0;
        pres_last  = 1'b0;
        pres_valid = 1'b0;

        nxt_idx  = idx_q + 1'b1;
        nxt_word = buf_q[nxt_idx];
        nxt_last = (nxt_idx == LAST_IDX);
        // A tvalid=0 slot inside SEND is a skipped zero word and never waits on tready.
        advance  = tready | (SKIP_ZERO & ~tvalid_q);

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    buf_d     = words;
                    idx_d     = '0;
                    state_d   = ST_SEND;
                    busy_d    = 1'b1;
                    pres_en   = 1'b1;
                    pres_word = words[DATA_W-1:0];
                    pres_last = (N_WORDS == 1);
                end
            end
            ST_SEND: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d    = '0;
                        tdata_d  = '0;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tkeep_d  = '0;
                        busy_d   = 1'b0;
                        if (ONE_SHOT != 0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d     = nxt_idx;
                        pres_en   = 1'b1;
                        pres_word = nxt_word;
                        pres_last = nxt_last;
                    end
                end
            end
            ST_DONE: begin
                tdata_d  = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tkeep_d  = '0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = '0;
                tdata_d  = '0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                tkeep_d  = '0;
                busy_d   = 1'b0;
                done_d   = 1'b0;
            end
        endcase

        // The final word is always sent, even when zero.
        if (pres_en) begin
            pres_valid = ~(SKIP_ZERO & (pres_word == '0) & ~pres_last);
            tvalid_d   = pres_valid;
            tdata_d    = pres_valid ? pres_word : '0;
            tkeep_d    = pres_valid ? {KEEP_W{1'b1}} : '0;
            tlast_d    = pres_valid & pres_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            buf_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tkeep_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tkeep_q  <= tkeep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tdata  = tdata_q;
    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tkeep  = tkeep_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_sender.sv
//==============================================================================
// Module      : tb_axis_frame_sender
// Description : Self-checking bench for axis_frame_sender (one-shot and re-arm
//               instances); honours AXIS_FRAME_SKIP_ZERO_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axis_frame_sender;

    localparam int DW = 32;
    localparam int NW = 3;
`ifdef AXIS_FRAME_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam logic [31:0] WA = 32'hA1A1_A1A1;
    localparam logic [31:0] WB = 32'hB2B2_B2B2;
    localparam logic [31:0] WC = 32'hC3C3_C3C3;

    logic                clk = 1'b0;
    logic                reset;
    logic [NW*DW-1:0]    words;
    logic                en1, tready1, en0, tready0;
    logic [DW-1:0]       tdata1, tdata0;
    logic                tvalid1, tlast1, busy1, done1;
    logic                tvalid0, tlast0, busy0, done0;
    logic [DW/8-1:0]     tkeep1, tkeep0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_frame_sender #(.DATA_W(DW), .N_WORDS(NW), .ONE_SHOT(1)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .words(words), .tready(tready1),
        .tdata(tdata1), .tvalid(tvalid1), .tlast(tlast1), .tkeep(tkeep1),
        .busy(busy1), .done(done1)
    );

    axis_frame_sender #(.DATA_W(DW), .N_WORDS(NW), .ONE_SHOT(0)) dut0 (
        .clk(clk), .reset(reset), .en(en0), .words(words), .tready(tready0),
        .tdata(tdata0), .tvalid(tvalid0), .tlast(tlast0), .tkeep(tkeep0),
        .busy(busy0), .done(done0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Checks one observed cycle of the one-shot instance.
    task automatic chk1(input string name, input logic v, input logic [31:0] d, input logic l);
        chk({name, ".tvalid"}, 64'(tvalid1), 64'(v));
        chk({name, ".tdata"},  64'(tdata1),  64'(d));
        chk({name, ".tlast"},  64'(tlast1),  64'(l));
        chk({name, ".tkeep"},  64'(tkeep1),  v ? 64'hF : 64'h0);
    endtask

    typedef struct {
        logic [2:0][31:0] w;
        logic [2:0]       v;
        logic [2:0][31:0] d;
        logic [2:0]       l;
    } vec_t;

    // Reference model: a frame is the ordered list of words that carry tvalid=1.
    logic [32:0] expq[$];

    task automatic model_push(input logic [NW*DW-1:0] ws);
        for (int i = 0; i < NW; i++) begin
            logic [31:0] w;
            w = ws[i*DW +: DW];
            if (SKIP && w == 32'h0 && i != NW-1) continue;
            expq.push_back({(i == NW-1), w});
        end
    endtask

    function automatic logic [31:0] rand_word();
        return ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
    endfunction

    vec_t tbl[5];

    initial begin
        reset   = 1'b0;
        words   = '0;
        en1     = 1'b0;
        tready1 = 1'b0;
        en0     = 1'b0;
        tready0 = 1'b0;

        tbl[0].w = {WC, WB, WA};                 tbl[0].v = 3'b111;
        tbl[0].d = {WC, WB, WA};                 tbl[0].l = 3'b100;
        tbl[1].w = {32'd3, 32'd2, 32'd1};        tbl[1].v = 3'b111;
        tbl[1].d = {32'd3, 32'd2, 32'd1};        tbl[1].l = 3'b100;
        tbl[2].w = {32'd0, 32'd0, WA};           tbl[2].v = SKIP ? 3'b101 : 3'b111;
        tbl[2].d = {32'd0, 32'd0, WA};           tbl[2].l = 3'b100;
        tbl[3].w = {32'd0, 32'd5, 32'd0};        tbl[3].v = SKIP ? 3'b110 : 3'b111;
        tbl[3].d = {32'd0, 32'd5, 32'd0};        tbl[3].l = 3'b100;
        tbl[4].w = {32'hFFFF_FFFF, 32'd0, 32'd7}; tbl[4].v = SKIP ? 3'b101 : 3'b111;
        tbl[4].d = {32'hFFFF_FFFF, 32'd0, 32'd7}; tbl[4].l = 3'b100;

        // Reset state of both instances
        do_reset();
        chk("rst1.out", {tdata1, tvalid1, tlast1, tkeep1, busy1, done1}, 64'h0);
        chk("rst0.out", {tdata0, tvalid0, tlast0, tkeep0, busy0, done0}, 64'h0);

        // Table-driven frames on the one-shot instance, tready always 1
        for (int t = 0; t < 5; t++) begin
            do_reset();
            words   = tbl[t].w;
            en1     = 1'b1;
            tready1 = 1'b1;
            tick();
            en1 = 1'b0;
            for (int k = 0; k < 3; k++) begin
                chk1($sformatf("tbl%0d.c%0d", t, k), tbl[t].v[k], tbl[t].d[k], tbl[t].l[k]);
                chk($sformatf("tbl%0d.c%0d.busy", t, k), 64'(busy1), 64'h1);
                tick();
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tbl%0d.done%0d", t, k), {tvalid1, tlast1, tdata1, busy1, done1}, 64'h1);
                en1 = 1'b1;
                tick();
            end
            en1 = 1'b0;
        end

        // Backpressure on word1 for four cycles
        do_reset();
        words = {WC, WB, WA}; en1 = 1'b1; tready1 = 1'b1;
        tick();
        en1 = 1'b0;
        chk1("bp.w0", 1'b1, WA, 1'b0);
        tick();
        tready1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk1($sformatf("bp.hold%0d", k), 1'b1, WB, 1'b0);
            tick();
        end
        tready1 = 1'b1;
        chk1("bp.w1", 1'b1, WB, 1'b0);
        tick();
        chk1("bp.w2", 1'b1, WC, 1'b1);
        tick();
        chk1("bp.end", 1'b0, 32'h0, 1'b0);
        chk("bp.done", 64'(done1), 64'h1);

        // Snapshot isolation: payload overwritten right after en
        do_reset();
        words = {WC, WB, WA}; en1 = 1'b1; tready1 = 1'b1;
        tick();
        en1 = 1'b0;
        words = '1;
        chk1("snap.w0", 1'b1, WA, 1'b0);
        tick();
        chk1("snap.w1", 1'b1, WB, 1'b0);
        tick();
        chk1("snap.w2", 1'b1, WC, 1'b1);
        tick();
        chk1("snap.end", 1'b0, 32'h0, 1'b0);

        // Reset while word1 pending, then restart from word0
        do_reset();
        words = {WC, WB, WA}; en1 = 1'b1; tready1 = 1'b1;
        tick();
        en1 = 1'b0;
        tick();
        tready1 = 1'b0;
        chk1("rmid.w1", 1'b1, WB, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmid.out", {tdata1, tvalid1, tlast1, tkeep1, busy1, done1}, 64'h0);
        tready1 = 1'b1; en1 = 1'b1;
        tick();
        en1 = 1'b0;
        chk1("rmid.r0", 1'b1, WA, 1'b0);
        tick();
        chk1("rmid.r1", 1'b1, WB, 1'b0);
        tick();
        chk1("rmid.r2", 1'b1, WC, 1'b1);
        tick();
        chk("rmid.done", 64'(done1), 64'h1);

        // Re-arm instance: en held high gives A,B,C,gap,A,B,C
        do_reset();
        words = {WC, WB, WA}; en0 = 1'b1; tready0 = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            logic v;
            logic [31:0] d;
            v = (k != 3);
            d = (k == 3) ? 32'h0 : ((k % 4) == 0 ? WA : ((k % 4) == 1 ? WB : WC));
            chk($sformatf("b2b.c%0d.tvalid", k), 64'(tvalid0), 64'(v));
            chk($sformatf("b2b.c%0d.tdata", k),  64'(tdata0),  64'(d));
            chk($sformatf("b2b.c%0d.tlast", k),  64'(tlast0),  64'((k % 4) == 2));
            chk($sformatf("b2b.c%0d.done", k),   64'(done0),   64'h0);
            tick();
        end
        en0 = 1'b0;

        // Randomized traffic on the re-arm instance against the queue model
        do_reset();
        expq.delete();
        begin
            bit active;
            bit exp_busy;
            int gap;
            int frames;
            active = 1'b0; exp_busy = 1'b0; gap = 0; frames = 0;
            for (int cyc = 0; cyc < 2030; cyc++) begin
                bit allow_new;
                allow_new = (cyc < 2000);
                chk("rnd.busy", 64'(busy0), 64'(exp_busy));
                if (tvalid0) begin
                    if (expq.size() == 0) begin
                        chk("rnd.unexpected_beat", 64'(tvalid0), 64'h0);
                    end else begin
                        chk("rnd.tdata", 64'(tdata0), 64'(expq[0][31:0]));
                        chk("rnd.tlast", 64'(tlast0), 64'(expq[0][32]));
                        chk("rnd.tkeep", 64'(tkeep0), 64'hF);
                    end
                end else begin
                    chk("rnd.idle_out", {tdata0, tlast0, tkeep0}, 64'h0);
                end
                en0     = 1'b0;
                tready0 = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
                words   = {rand_word(), rand_word(), rand_word()};
                if (tvalid0 && tready0 && expq.size() > 0) begin
                    logic [32:0] b;
                    b = expq.pop_front();
                    if (b[32]) begin
                        active   = 1'b0;
                        exp_busy = 1'b0;
                        frames++;
                        gap = $urandom_range(0, 3);
                    end
                end else if (!active && allow_new) begin
                    if (gap == 0) begin
                        en0      = 1'b1;
                        active   = 1'b1;
                        exp_busy = 1'b1;
                        model_push(words);
                    end else begin
                        gap--;
                    end
                end
                tick();
            end
            en0 = 1'b0;
            chk("rnd.drained", 64'(expq.size()), 64'h0);
            chk("rnd.enough_frames", 64'(frames >= 50), 64'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
